icache_refill_unit: RTL and testbench

- Sits directly downstream of the instruction cache's L2 interface.
- Accepts one block-refill request per miss and converts it into a single burst read on a narrower memory bus.
- Assembles the returned beats into a BLOCK_WIDTH line, then pulses ready_o with the full block.
- Blocking, single outstanding refill; a request can only be accepted when idle.

---
 rtl/icache_pkg.sv | 25 ++
 rtl/icache_refill_unit.sv | 94 +++++++++
 tb/tb_icache_refill_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared icache types and geometry helpers.
// Refill FSM state enum plus beat/offset derivations.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    DONE
  } refill_state_t;

  function automatic int beats_f(
    input int block_w,
    input int mem_w
  );
    return block_w / mem_w;
  endfunction

  function automatic int offset_bits_f(
    input int block_w
  );
    return $clog2(block_w / 8);
  endfunction

endpackage

// File: rtl/icache_refill_unit.sv
// Blocking icache line refill: one burst read per miss, beats assembled.
// Ports: icache side (valid_i/address_i -> ready_o/data_o/busy_o), mem req/resp, refill_count_o.
module icache_refill_unit
  import icache_pkg::*;
#(
  parameter int ADDRESS_BITS = 32,
  parameter int BLOCK_WIDTH  = 256,
  parameter int MEM_WIDTH    = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  input  logic [ADDRESS_BITS-1:0] address_i,
  output logic                    ready_o,
  output logic [BLOCK_WIDTH-1:0]  data_o,
  output logic                    busy_o,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic [ADDRESS_BITS-1:0] mem_addr_o,
  output logic [7:0]              mem_len_o,
  input  logic                    mem_resp_valid_i,
  input  logic [MEM_WIDTH-1:0]    mem_resp_data_i,
  output logic [31:0]             refill_count_o
);

  localparam int BEATS       = beats_f(BLOCK_WIDTH, MEM_WIDTH);
  localparam int OFFSET_BITS = offset_bits_f(BLOCK_WIDTH);
  localparam int CNT_W       = $clog2(BEATS);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  refill_state_t    state;
  logic [CNT_W-1:0] beat_cnt;

  // Line offset bits are dropped when forming the block base.
  logic unused_offset;
  assign unused_offset = ^address_i[OFFSET_BITS-1:0];

  assign mem_len_o = 8'(BEATS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ready_o         <= 1'b0;
      busy_o          <= 1'b0;
      mem_req_valid_o <= 1'b0;
      mem_addr_o      <= '0;
      data_o          <= '0;
      beat_cnt        <= '0;
      refill_count_o  <= '0;
    end else begin
      ready_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid_i) begin
            mem_addr_o <= {address_i[ADDRESS_BITS-1:OFFSET_BITS],
                           {OFFSET_BITS{1'b0}}};
            beat_cnt        <= '0;
            mem_req_valid_o <= 1'b1;
            busy_o          <= 1'b1;
            state           <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            state           <= DATA;
          end
        end
        DATA: begin
          if (mem_resp_valid_i) begin
            data_o[int'(beat_cnt)*MEM_WIDTH +: MEM_WIDTH] <= mem_resp_data_i;
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              ready_o  <= 1'b1;
              state    <= DONE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
          if (refill_count_o != '1) begin
            refill_count_o <= refill_count_o + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_unit.sv
// Self-checking bench for icache_refill_unit.
// Vector table of refills plus hand sequences; scoreboard on ready_o.
module tb_icache_refill_unit;

  localparam int AW = 32;
  localparam int BW = 256;
  localparam int MW = 64;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_i;
  logic [AW-1:0] address_i;
  logic          ready_o;
  logic [BW-1:0] data_o;
  logic          busy_o;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i;
  logic [AW-1:0] mem_addr_o;
  logic [7:0]    mem_len_o;
  logic          mem_resp_valid_i;
  logic [MW-1:0] mem_resp_data_i;
  logic [31:0]   refill_count_o;

  icache_refill_unit #(
    .ADDRESS_BITS(AW),
    .BLOCK_WIDTH (BW),
    .MEM_WIDTH   (MW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_i         (valid_i),
    .address_i       (address_i),
    .ready_o         (ready_o),
    .data_o          (data_o),
    .busy_o          (busy_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_addr_o      (mem_addr_o),
    .mem_len_o       (mem_len_o),
    .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_data_i (mem_resp_data_i),
    .refill_count_o  (refill_count_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [BW-1:0] sb_q[$];
  logic [31:0]   exp_count = '0;
  logic [BW-1:0] exp_data = '0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [MW-1:0] b0;
    logic [MW-1:0] b1;
    logic [MW-1:0] b2;
    logic [MW-1:0] b3;
    int            rw;
    int            gap;
    logic [AW-1:0] exp_addr;
    bit            spur;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(
    input string         name,
    input logic [BW-1:0] act,
    input logic [BW-1:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every ready_o pulse must match the oldest pending block.
  logic ready_q = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ready_o === 1'b1) begin
      chk("ready_one_cycle", BW'(ready_q), BW'(0));
      chk("ready_expected", BW'(sb_q.size() != 0), BW'(1));
      if (sb_q.size() != 0) begin
        chk("sb_data", data_o, sb_q.pop_front());
      end
    end
    ready_q = (rst_n === 1'b1) ? ready_o : 1'b0;
  end

  task automatic beat(input logic [MW-1:0] d);
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = d;
    @(posedge clk); #1;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = MW'({$urandom, $urandom});
  endtask

  task automatic do_refill(input vec_t v);
    logic [MW-1:0] bt[NB];
    bt = '{v.b0, v.b1, v.b2, v.b3};
    @(posedge clk); #1;
    valid_i   = 1'b1;
    address_i = v.addr;
    sb_q.push_back({v.b3, v.b2, v.b1, v.b0});
    @(posedge clk); #1;
    valid_i   = 1'b0;
    address_i = ~v.addr;
    chk("req_valid", BW'(mem_req_valid_o), BW'(1));
    chk("req_addr", BW'(mem_addr_o), BW'(v.exp_addr));
    chk("req_len", BW'(mem_len_o), BW'(NB - 1));
    chk("busy_req", BW'(busy_o), BW'(1));
    for (int i = 0; i < v.rw; i++) begin
      mem_req_ready_i  = 1'b0;
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = 64'hBAD0_BAD0_BAD0_BAD0;
      @(posedge clk); #1;
      chk("hold_valid", BW'(mem_req_valid_o), BW'(1));
      chk("hold_addr", BW'(mem_addr_o), BW'(v.exp_addr));
    end
    mem_resp_valid_i = 1'b0;
    mem_req_ready_i  = 1'b1;
    @(posedge clk); #1;
    mem_req_ready_i = 1'b0;
    chk("req_drop", BW'(mem_req_valid_o), BW'(0));
    for (int k = 0; k < NB; k++) begin
      for (int g = 0; g < v.gap; g++) begin
        if (v.spur && k == 2) begin
          valid_i   = 1'b1;
          address_i = 32'h5555_5555;
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
        chk("gap_no_ready", BW'(ready_o), BW'(0));
      end
      beat(bt[k]);
    end
    chk("ready_pulse", BW'(ready_o), BW'(1));
    @(posedge clk); #1;
    chk("ready_low", BW'(ready_o), BW'(0));
    chk("busy_idle", BW'(busy_o), BW'(0));
    exp_count = exp_count + 1;
    exp_data  = {v.b3, v.b2, v.b1, v.b0};
    chk("count", BW'(refill_count_o), BW'(exp_count));
    chk("data_hold", data_o, exp_data);
    if (v.spur) begin
      @(posedge clk); #1;
      chk("spur_not_taken", BW'(busy_o), BW'(0));
      chk("spur_addr", BW'(mem_addr_o), BW'(v.exp_addr));
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    sb_q.delete();
    exp_count = '0;
    exp_data  = '0;
    #1;
    chk("rst_ready", BW'(ready_o), BW'(0));
    chk("rst_busy", BW'(busy_o), BW'(0));
    chk("rst_req_valid", BW'(mem_req_valid_o), BW'(0));
    chk("rst_addr", BW'(mem_addr_o), BW'(0));
    chk("rst_data", data_o, exp_data);
    chk("rst_count", BW'(refill_count_o), BW'(exp_count));
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    vecs[0] = '{32'h0000_1234, {16{4'h1}}, {16{4'h2}}, {16{4'h3}},
                {16{4'h4}}, 0, 0, 32'h0000_1220, 1'b0};
    vecs[1] = '{32'h0000_ABFF, 64'h0123_4567_89AB_CDEF,
                64'hFEDC_BA98_7654_3210, 64'hDEAD_BEEF_0000_0001,
                64'h8000_0000_CAFE_F00D, 5, 0, 32'h0000_ABE0, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, {16{4'hF}}, 64'h0, {16{4'hA}},
                {16{4'h5}}, 1, 2, 32'hFFFF_FFE0, 1'b1};
    vecs[3] = '{32'h0000_0040, 64'h1, 64'h2, 64'h3, 64'h4,
                0, 1, 32'h0000_0040, 1'b0};

    valid_i          = 1'b0;
    address_i        = '0;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = '0;
    rst_n            = 1'b1;
    #2;
    apply_reset();

    for (int i = 0; i < 4; i++) begin
      do_refill(vecs[i]);
    end

    // Response beats while idle must be ignored.
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = 64'hDEAD_DEAD_DEAD_DEAD;
    repeat (2) @(posedge clk);
    #1;
    mem_resp_valid_i = 1'b0;
    chk("idle_resp_data", data_o, exp_data);
    chk("idle_resp_busy", BW'(busy_o), BW'(0));
    chk("idle_resp_count", BW'(refill_count_o), BW'(exp_count));

    // Reset in the middle of a burst, after two beats.
    @(posedge clk); #1;
    valid_i   = 1'b1;
    address_i = 32'h0000_3010;
    sb_q.push_back('0);
    @(posedge clk); #1;
    valid_i         = 1'b0;
    mem_req_ready_i = 1'b1;
    @(posedge clk); #1;
    mem_req_ready_i = 1'b0;
    beat(64'h7777_7777_7777_7777);
    beat(64'h8888_8888_8888_8888);
    apply_reset();
    v = '{32'h0000_2000, 64'hA1, 64'hB2, 64'hC3, 64'hD4,
          0, 0, 32'h0000_2000, 1'b0};
    do_refill(v);

    // Back-to-back: valid_i held through DONE.
    apply_reset();
    @(posedge clk); #1;
    valid_i         = 1'b1;
    address_i       = 32'h0000_4000;
    mem_req_ready_i = 1'b1;
    sb_q.push_back({64'h14, 64'h13, 64'h12, 64'h11});
    @(posedge clk); #1;
    address_i = 32'h0000_5008;
    @(posedge clk); #1;
    beat(64'h11);
    beat(64'h12);
    beat(64'h13);
    beat(64'h14);
    chk("b2b_ready1", BW'(ready_o), BW'(1));
    sb_q.push_back({64'h24, 64'h23, 64'h22, 64'h21});
    @(posedge clk); #1;
    chk("b2b_idle_gap", BW'(busy_o), BW'(0));
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("b2b_req2", BW'(mem_req_valid_o), BW'(1));
    chk("b2b_addr2", BW'(mem_addr_o), BW'(32'h0000_5000));
    @(posedge clk); #1;
    mem_req_ready_i = 1'b0;
    beat(64'h21);
    beat(64'h22);
    beat(64'h23);
    beat(64'h24);
    chk("b2b_ready2", BW'(ready_o), BW'(1));
    @(posedge clk); #1;
    chk("b2b_count", BW'(refill_count_o), BW'(2));
    chk("b2b_data", data_o, {64'h24, 64'h23, 64'h22, 64'h21});

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", BW'(sb_q.size()), BW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
